// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller.
package counter_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_ONESHOT_UP   = 2'd0,
        MODE_ONESHOT_DOWN = 2'd1,
        MODE_PERIODIC_UP  = 2'd2,
        MODE_BOUNCE       = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command handshake bundle: valid/ready plus the mode and terminal value.
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [WIDTH-1:0] cmd_limit;

    modport master (output cmd_valid, output cmd_mode, output cmd_limit, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_mode, input cmd_limit, output cmd_ready);
endinterface

// File: rtl/updown_counter.sv
// Loadable up/down count register; clear beats load, load beats enable.
module updown_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/counter_ctrl.sv
// Job controller around an up/down counter: one-shot, periodic and bounce modes
// with pause, abort and a terminal-count strobe.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    counter_ctrl_if.slave    cmd,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);
    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_clear;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] endpoint;
    logic             accept;
    mode_e            cmd_mode_e;
    logic             cmd_oneshot;
    logic             cmd_limit_zero;

    assign cmd.cmd_ready    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !abort && !rst;
    assign accept           = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd_mode_e       = mode_e'(cmd.cmd_mode);
    assign cmd_oneshot      = (cmd_mode_e == MODE_ONESHOT_UP) || (cmd_mode_e == MODE_ONESHOT_DOWN);
    assign cmd_limit_zero   = (cmd.cmd_limit == '0);
    assign step_val         = dir_q ? count + WIDTH'(1) : count - WIDTH'(1);
    assign endpoint         = dir_q ? limit_q : '0;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        limit_d      = limit_q;
        dir_d        = dir_q;
        tc_d         = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        if (abort) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
            dir_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        mode_d   = cmd_mode_e;
                        limit_d  = cmd.cmd_limit;
                        cnt_load = 1'b1;
                        dir_d    = (cmd_mode_e != MODE_ONESHOT_DOWN);
                        if (cmd_mode_e == MODE_ONESHOT_DOWN) begin
                            cnt_load_val = cmd.cmd_limit;
                        end
                        // Start value already equals the endpoint when L is zero
                        tc_d    = cmd_limit_zero;
                        state_d = (cmd_oneshot && cmd_limit_zero) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        case (mode_q)
                            MODE_PERIODIC_UP: begin
                                if (count == limit_q) begin
                                    cnt_load = 1'b1;
                                    tc_d     = (limit_q == '0);
                                end else begin
                                    cnt_en = 1'b1;
                                    tc_d   = (step_val == limit_q);
                                end
                            end
                            MODE_BOUNCE: begin
                                if (limit_q == '0) begin
                                    tc_d = 1'b1;
                                end else begin
                                    cnt_en = 1'b1;
                                    if (step_val == endpoint) begin
                                        tc_d  = 1'b1;
                                        dir_d = !dir_q;
                                    end
                                end
                            end
                            default: begin
                                cnt_en = 1'b1;
                                if (step_val == endpoint) begin
                                    tc_d    = 1'b1;
                                    state_d = ST_DONE;
                                end
                            end
                        endcase
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ONESHOT_UP;
            limit_q <= '0;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    updown_counter #(.WIDTH(WIDTH)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up_down  (dir_q),
        .count    (count)
    );

    assign dir      = dir_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tc_pulse = tc_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random traffic against a job-level model.
module tb_counter_ctrl;
    localparam int unsigned W   = 8;
    localparam int          MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count;
    logic         dir, busy, done, tc_pulse;

    counter_ctrl_if #(.WIDTH(W)) cif ();

    counter_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cif),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .tc_pulse (tc_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Job-level reference: is a job active, is it parked, has it finished
    int m_cnt    = 0;
    int m_mode   = 0;
    int m_lim    = 0;
    bit m_dir    = 1'b1;
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;
    bit m_paused = 1'b0;
    bit m_tc     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit a, input bit p, input bit v, input int md, input int lim);
        int target;
        if (r || a) begin
            m_busy = 0; m_done = 0; m_paused = 0; m_cnt = 0; m_dir = 1; m_tc = 0;
        end else if (!m_busy && v) begin
            m_mode   = md;
            m_lim    = lim;
            m_dir    = (md != 1);
            m_cnt    = (md == 1) ? lim : 0;
            m_tc     = (lim == 0);
            m_paused = 0;
            m_done   = (lim == 0) && (md < 2);
            m_busy   = !m_done;
        end else if (m_busy && m_paused) begin
            m_tc = 0;
            if (!p) m_paused = 0;
        end else if (m_busy && p) begin
            m_paused = 1;
            m_tc     = 0;
        end else if (m_busy) begin
            if (m_mode == 2) begin
                m_cnt = (m_cnt == m_lim) ? 0 : m_cnt + 1;
                m_tc  = (m_cnt == m_lim);
            end else if (m_mode == 3 && m_lim == 0) begin
                m_tc = 1;
            end else begin
                m_cnt  = (m_cnt + (m_dir ? 1 : MOD - 1)) % MOD;
                target = m_dir ? m_lim : 0;
                m_tc   = (m_cnt == target);
                if (m_tc && m_mode == 3) begin
                    m_dir = !m_dir;
                end else if (m_tc) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit a, input bit p, input bit v, input int md, input int lim);
        @(negedge clk);
        rst           = r;
        abort         = a;
        pause         = p;
        cif.cmd_valid = v;
        cif.cmd_mode  = 2'(md);
        cif.cmd_limit = W'(lim);
        #1;
        check_eq("cmd_ready", 32'(cif.cmd_ready), 32'(!m_busy && !a && !r));
        @(posedge clk);
        model_step(r, a, p, v, md, lim);
        #1;
        check_eq("count", 32'(count), 32'(m_cnt));
        check_eq("dir", 32'(dir), 32'(m_dir));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("tc_pulse", 32'(tc_pulse), 32'(m_tc));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit rp;
        int lim;

        cif.cmd_valid = 1'b0;
        cif.cmd_mode  = 2'd0;
        cif.cmd_limit = '0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 3);
        idle_cycles(1);

        // One-shot up to 3, then hold in done
        cyc(0, 0, 0, 1, 0, 3);
        idle_cycles(6);
        check_eq("oneshot_up_hold", 32'(count), 32'd3);
        check_eq("oneshot_up_done", 32'(done), 32'd1);

        // Bounce between 0 and 2
        cyc(0, 0, 0, 1, 3, 2);
        idle_cycles(8);
        cyc(0, 1, 0, 0, 0, 0);

        // Periodic up through the 255 -> 0 wrap
        cyc(0, 0, 0, 1, 2, 255);
        idle_cycles(258);
        check_eq("periodic_no_done", 32'(done), 32'd0);
        cyc(0, 1, 0, 0, 0, 0);
        check_eq("periodic_abort_count", 32'(count), 32'd0);

        // One-shot down from 5 with a pause at 3
        cyc(0, 0, 0, 1, 1, 5);
        idle_cycles(2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        check_eq("paused_count", 32'(count), 32'd3);
        idle_cycles(5);

        // Command during run ignored; abort beats command in done
        cyc(0, 0, 0, 1, 0, 4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 9);
        idle_cycles(3);
        cyc(0, 1, 0, 1, 2, 7);
        check_eq("abort_in_done_busy", 32'(busy), 32'd0);

        // Reset mid-run at count 7
        cyc(0, 0, 0, 1, 0, 20);
        idle_cycles(7);
        check_eq("pre_reset_count", 32'(count), 32'd7);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Zero terminal value in every mode
        for (int md = 0; md < 4; md++) begin
            cyc(0, 0, 0, 1, md, 0);
            idle_cycles(4);
            cyc(0, 1, 0, 0, 0, 0);
        end

        // Random traffic
        rp = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0:       lim = 0;
                1:       lim = 1;
                2:       lim = 2;
                3:       lim = 255;
                default: lim = int'($urandom_range(3, 20));
            endcase
            if ($urandom_range(0, 9) == 0) rp = !rp;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0), rp,
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), lim);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, count width; SHALL support 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_mode  input  2  0 ONESHOT_UP, 1 ONESHOT_DOWN, 2 PERIODIC_UP, 3 BOUNCE.
REQ-007 cmd_limit  input  WIDTH  terminal value L; sampled only at acceptance.
REQ-008 pause  input  1  hold count while high.
REQ-009 abort  input  1  cancel the current job.
REQ-010 count  output  WIDTH  registered count value.
REQ-011 dir  output  1  current direction: 1 up, 0 down.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 done  output  1  high in DONE.
REQ-014 tc_pulse  output  1  one-cycle terminal-count strobe.

Function
REQ-015 States SHALL be IDLE, RUN, PAUSE and DONE.
REQ-016 cmd_ready SHALL equal (IDLE or DONE) && !abort && !rst; cmd_valid in RUN or PAUSE SHALL be ignored.
REQ-017 Acceptance at cycle N SHALL latch mode and L; at N+1 state=RUN and count=start (L for ONESHOT_DOWN, else 0), with dir=0 for ONESHOT_DOWN, else 1.
REQ-018 In RUN with pause low, count SHALL step by 1 per cycle in direction dir, modulo 2^WIDTH.
REQ-019 Endpoint SHALL be L when dir=1 and 0 when dir=0; tc_pulse SHALL be high in exactly the cycles where a load or step makes count equal the endpoint.
REQ-020 ONESHOT modes: in the cycle count reaches the endpoint, state SHALL become DONE; count holds until abort or new command.
REQ-021 PERIODIC_UP: the step after count==L SHALL load 0; it runs until abort.
REQ-022 BOUNCE: at an endpoint, dir SHALL invert and the next step moves away (L=1 gives 0,1,0,1...); it runs until abort.
REQ-023 L=0: ONESHOT_* SHALL reach DONE with tc_pulse at N+1; PERIODIC_UP and BOUNCE SHALL hold count=0 with tc_pulse high every RUN cycle.
REQ-024 pause high in RUN SHALL move to PAUSE next cycle with count frozen; pause low in PAUSE SHALL return to RUN and stepping resumes the following cycle; tc_pulse SHALL be 0 in PAUSE.
REQ-025 abort SHALL have priority over pause, step and command: next cycle state=IDLE, count=0, dir=1, tc_pulse=0, from any state.
REQ-026 A command accepted in DONE SHALL restart per REQ-017; done drops at N+1.

Reset
REQ-027 rst high at an edge SHALL force state=IDLE, count=0, dir=1, busy=0, done=0 and tc_pulse=0, overriding abort and commands, including mid-RUN or mid-PAUSE.
REQ-028 cmd_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.

Structure
REQ-029 Package counter_ctrl_pkg SHALL hold the mode enum, the state enum and the default WIDTH constant.
REQ-030 Sub-module updown_counter (sync clear, load, en, up_down, WIDTH) SHALL hold the count register; counter_ctrl holds the FSM, the latched mode/L, dir and tc logic.
REQ-031 All outputs except cmd_ready SHALL be registered.

Verification
REQ-032 ONESHOT_UP, L=3 accepted at N -> count 0,1,2,3 at N+1..N+4; tc_pulse and done at N+4; done stays 1; count stays 3.
REQ-033 BOUNCE, L=2 -> count 0,1,2,1,0,1,2; tc_pulse on each 2 and 0 after the first; dir toggles at each endpoint.
REQ-034 PERIODIC_UP, WIDTH=8, L=255 -> count 254,255,0; tc at 255; no DONE; abort -> next cycle IDLE, count=0.
REQ-035 ONESHOT_DOWN, L=5, pause high for 3 cycles at count=3 -> count holds 3, busy=1, tc=0; after release 2,1,0, then DONE.
REQ-036 cmd_valid during RUN -> cmd_ready=0 and no change; abort+cmd_valid in DONE -> IDLE, command not accepted; rst mid-RUN at count=7 -> IDLE, count=0, cmd_ready=1 the cycle after release.
REQ-037 L=0 in each mode -> behaviour per REQ-023.
